// File: rtl/cam_cfg_sequencer_if.sv
// ============================================================================
//  Module  : cam_cfg_sequencer_if
//  Brief   : Write-request bus between the config sequencer and the SCCB master.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

interface cam_cfg_sequencer_if;
    logic       valid;
    logic [7:0] addr;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/cam_cfg_sequencer.sv
// ============================================================================
//  Module  : cam_cfg_sequencer
//  Brief   : Walks a {reg_addr, reg_data} ROM on cfg_start and issues SCCB writes.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module cam_cfg_sequencer #(
    parameter int unsigned ROM_AW       = 8,
    parameter int unsigned DELAY_CYCLES = 1250000,
    parameter int unsigned TIMEOUT      = 2500000,
    parameter logic [15:0] END_MARKER   = 16'hFFFF,
    parameter logic [15:0] DELAY_MARKER = 16'hFFF0
) (
    input  wire logic              i_sysclk,
    input  wire logic              i_rstn,
    input  wire logic              i_cfg_start,
    output logic                   o_cfg_done,
    output logic                   o_cfg_err,
    output logic                   o_busy,
    output logic [ROM_AW-1:0]      o_rom_addr,
    input  wire logic [15:0]       i_rom_data,
    cam_cfg_sequencer_if.master    sccb
);

    localparam int unsigned c_DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ROM_AW-1:0]  c_LAST_ADDR = {ROM_AW{1'b1}};
    localparam logic [c_DLY_W-1:0] c_DLY_LAST  = c_DLY_W'(DELAY_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_SEND   = 3'd3,
        S_DELAY  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [ROM_AW-1:0]   r_rom_addr, w_rom_addr_nxt;
    logic                r_done,     w_done_nxt;
    logic                r_err,      w_err_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_valid,    w_valid_nxt;
    logic [7:0]          r_addr,     w_addr_nxt;
    logic [7:0]          r_data,     w_data_nxt;
    logic [c_DLY_W-1:0]  r_dly_cnt,  w_dly_cnt_nxt;
    logic [c_TMO_W-1:0]  r_tmo_cnt,  w_tmo_cnt_nxt;

    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_dly_cnt  <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rom_addr_nxt = r_rom_addr;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_valid_nxt    = r_valid;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_dly_cnt_nxt  = r_dly_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_cfg_start) begin
                    w_rom_addr_nxt = '0;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (i_rom_data == END_MARKER) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (i_rom_data == DELAY_MARKER) begin
                    w_dly_cnt_nxt = '0;
                    w_state_nxt   = S_DELAY;
                end else begin
                    w_addr_nxt    = i_rom_data[15:8];
                    w_data_nxt    = i_rom_data[7:0];
                    w_valid_nxt   = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (r_valid && sccb.ready) begin
                    w_valid_nxt = 1'b0;
                    // The last ROM slot ends the walk instead of wrapping to 0.
                    if (r_rom_addr == c_LAST_ADDR) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
                        w_state_nxt    = S_FETCH;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + c_TMO_W'(1);
                end
            end
            S_DELAY: begin
                if (r_dly_cnt == c_DLY_LAST) begin
                    if (r_rom_addr == c_LAST_ADDR) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
                        w_state_nxt    = S_FETCH;
                    end
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt + c_DLY_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    assign o_cfg_done = r_done;
    assign o_cfg_err  = r_err;
    assign o_busy     = r_busy;
    assign o_rom_addr = r_rom_addr;
    assign sccb.valid = r_valid;
    assign sccb.addr  = r_addr;
    assign sccb.data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_cam_cfg_sequencer.sv
// ============================================================================
//  Module  : tb_cam_cfg_sequencer
//  Brief   : Randomized self-checking bench for cam_cfg_sequencer.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cam_cfg_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int DLY   = 20;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic done, err, busy;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_q = '0;
    logic [15:0]   rom [DEPTH];

    always #5 clk = ~clk;

    cam_cfg_sequencer_if sccb_if();

    cam_cfg_sequencer #(
        .ROM_AW       (AW),
        .DELAY_CYCLES (DLY),
        .TIMEOUT      (TMO),
        .END_MARKER   (16'hFFFF),
        .DELAY_MARKER (16'hFFF0)
    ) u_dut (
        .i_sysclk    (clk),
        .i_rstn      (rstn),
        .i_cfg_start (start),
        .o_cfg_done  (done),
        .o_cfg_err   (err),
        .o_busy      (busy),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_q),
        .sccb        (sccb_if)
    );

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_q <= rom[rom_addr];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int mode = 0;
    bit inject = 1'b0;
    int wait_left = 0;
    bit pend = 1'b0;
    logic [7:0] pa, pd;
    int n_unstable, n_both, n_valid_cyc;
    int start_cyc, first_valid_cyc, done_cyc;
    logic [15:0] got_q[$];
    int          acc_cyc[$];
    logic [15:0] exp_q[$];
    int          exp_nd[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: observe at negedge, then drive ready/start for the next posedge.
    task automatic step(input bit st);
        @(negedge clk);
        cyc++;
        if (busy && done) n_both++;
        if (sccb_if.valid) begin
            n_valid_cyc++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (pend && (!sccb_if.valid || sccb_if.addr !== pa || sccb_if.data !== pd))
            n_unstable++;
        case (mode)
            0: sccb_if.ready = 1'b1;
            2: sccb_if.ready = 1'b0;
            default: begin
                if (sccb_if.valid) begin
                    if (wait_left > 0) begin
                        sccb_if.ready = 1'b0;
                        wait_left--;
                    end else begin
                        sccb_if.ready = 1'b1;
                    end
                end else begin
                    sccb_if.ready = 1'($urandom_range(0, 1));
                end
            end
        endcase
        start = st | (inject && busy && ($urandom_range(0, 5) == 0));
        pend = (mode != 2) && sccb_if.valid && !sccb_if.ready;
        pa = sccb_if.addr;
        pd = sccb_if.data;
        if (sccb_if.valid && sccb_if.ready) begin
            got_q.push_back({sccb_if.addr, sccb_if.data});
            acc_cyc.push_back(cyc);
            wait_left = $urandom_range(0, 5);
        end
    endtask

    // Reference: the writes the ROM asks for, each with the delays preceding it.
    task automatic build_exp();
        int nd;
        exp_q.delete();
        exp_nd.delete();
        nd = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] == 16'hFFF0) begin
                nd++;
            end else begin
                exp_q.push_back(rom[i]);
                exp_nd.push_back(nd);
                nd = 0;
            end
        end
    endtask

    task automatic run(input int md, input bit inj);
        got_q.delete();
        acc_cyc.delete();
        mode = md;
        inject = 1'b0;
        pend = 1'b0;
        wait_left = $urandom_range(0, 5);
        n_unstable = 0;
        n_both = 0;
        n_valid_cyc = 0;
        first_valid_cyc = -1;
        step(1'b1);
        start_cyc = cyc;
        inject = inj;
        step(1'b0);
        chk("done_clr", {31'd0, done}, 32'd0);
        chk("err_clr", {31'd0, err}, 32'd0);
        for (int k = 0; k < 3000; k++) begin
            if (done) break;
            step(1'b0);
        end
        done_cyc = cyc;
        inject = 1'b0;
        chk("finish", {31'd0, done}, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic compare();
        int n;
        build_exp();
        chk("n_writes", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("wr%0d", i), {16'd0, got_q[i]}, {16'd0, exp_q[i]});
            if (i > 0 && exp_nd[i] > 0)
                chk($sformatf("gap%0d", i),
                    {31'd0, (acc_cyc[i] - acc_cyc[i-1]) >= exp_nd[i] * DLY + 2}, 32'd1);
        end
        chk("err", {31'd0, err}, 32'd0);
        chk("stable", n_unstable, 0);
        chk("excl", n_both, 0);
    endtask

    task automatic load_rom3(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    task automatic chk_reset_vals();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {28'd0, rom_addr}, 32'd0);
        chk("rst_valid", {31'd0, sccb_if.valid}, 32'd0);
        chk("rst_sccb", {16'd0, sccb_if.addr, sccb_if.data}, 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int len;
        sccb_if.ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
        mode = 2;
        rstn = 1'b0;
        repeat (3) step(1'b0);
        chk_reset_vals();
        rstn = 1'b1;

        // Two writes, ready always high: ordering, latency and done timing.
        load_rom3(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        run(0, 1'b0);
        compare();
        chk("first_valid_lat", first_valid_cyc - start_cyc, 3);
        if (acc_cyc.size() > 0)
            chk("done_lat", done_cyc - acc_cyc[acc_cyc.size()-1], 3);

        // Stalled ready with spurious starts.
        run(1, 1'b1);
        compare();

        // Delay entry between writes.
        load_rom3(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
        run(0, 1'b1);
        compare();
        if (acc_cyc.size() == 2)
            chk("delay_gap", {31'd0, (acc_cyc[1] - acc_cyc[0]) >= 22}, 32'd1);

        // Ready stuck low: timeout aborts with err and done.
        load_rom3(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        run(2, 1'b0);
        chk("tmo_writes", got_q.size(), 0);
        chk("tmo_valid_cycles", n_valid_cyc, TMO);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_done", {31'd0, done}, 32'd1);
        run(0, 1'b0);
        compare();

        // Reset in the middle of a stalled write.
        mode = 2;
        step(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (sccb_if.valid) break;
            step(1'b0);
        end
        chk("pre_rst_valid", {31'd0, sccb_if.valid}, 32'd1);
        rstn = 1'b0;
        step(1'b0);
        chk_reset_vals();
        rstn = 1'b1;
        run(0, 1'b0);
        compare();

        // Random ROM images, including full-depth walks and a trailing delay.
        for (int t = 0; t < 24; t++) begin
            len = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                if (i >= len) begin
                    rom[i] = 16'hFFFF;
                end else if ($urandom_range(0, 6) == 0) begin
                    rom[i] = 16'hFFF0;
                end else begin
                    w = 16'($urandom);
                    if (w == 16'hFFFF || w == 16'hFFF0) w = 16'h1234;
                    rom[i] = w;
                end
            end
            if (len == DEPTH && $urandom_range(0, 1) == 1) rom[DEPTH-1] = 16'hFFF0;
            run($urandom_range(0, 1), 1'($urandom_range(0, 1)));
            compare();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
